action_controller: RTL

- Input-side stage that feeds the runner's vertical-movement block.
- Turns three raw active-low push-buttons into clean one-cycle, one-hot `operation` pulses (big jump, small jump, drop).
- Generates the frame-rate `update` tick that advances the movement sequence.
- Locks out new actions while a movement sequence is still running, so the movement block never sees an action mid-sequence.

---
 rtl/action_controller.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/action_controller.sv
// -----------------------------------------------------------------------------
// action_controller
//
// Front end for the runner's vertical-movement block. Cleans up three raw
// active-low push-buttons, generates the frame-rate update tick and issues
// one-cycle one-hot action pulses, refusing new actions while a movement
// sequence is still running.
//
// Ports:
//   clk        system clock
//   reset      asynchronous active-low reset
//   key_n[2:0] raw buttons, active-low, asynchronous to clk
//              (bit0 big jump, bit1 small jump, bit2 drop)
//   enable     game running; 0 pauses the tick divider and blocks new actions
//   operation  one-hot action pulse, one clk wide (001 big, 010 small, 100 drop)
//   update     one-clk frame tick
//   busy       high while a movement sequence is in progress
// -----------------------------------------------------------------------------
module action_controller #(
  parameter int TICK_DIV        = 833333,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int BIG_LEN         = 10,
  parameter int SMALL_LEN       = 15,
  parameter int DROP_LEN        = 9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] key_n,
  input  logic       enable,
  output logic [2:0] operation,
  output logic       update,
  output logic       busy
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW = (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;

  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  // The counter holds the number of differing cycles already seen, so the
  // level is accepted on the cycle that would bring it to DEBOUNCE_CYCLES.
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);

  localparam logic [4:0] BIG_L   = 5'(BIG_LEN);
  localparam logic [4:0] SMALL_L = 5'(SMALL_LEN);
  localparam logic [4:0] DROP_L  = 5'(DROP_LEN);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_ACTIVE = 1'b1;

  // Priority select: big > small > drop when presses share a cycle.
  function automatic logic [2:0] f_select(input logic [2:0] press);
    logic [2:0] sel;
    if (press[0]) begin
      sel = 3'b001;
    end else if (press[1]) begin
      sel = 3'b010;
    end else if (press[2]) begin
      sel = 3'b100;
    end else begin
      sel = 3'b000;
    end
    return sel;
  endfunction

  // Sequence length matching a one-hot action code.
  function automatic logic [4:0] f_len(input logic [2:0] sel);
    logic [4:0] len;
    case (sel)
      3'b001:  len = BIG_L;
      3'b010:  len = SMALL_L;
      3'b100:  len = DROP_L;
      default: len = 5'd0;
    endcase
    return len;
  endfunction

  logic [2:0]    r_sync1;
  logic [2:0]    r_sync2;
  logic [2:0]    r_deb;
  logic [2:0]    r_deb_prev;
  logic [DW-1:0] r_deb_cnt [3];
  logic [TW-1:0] r_tick_cnt;
  logic          r_update;
  logic [0:0]    r_state;
  logic [4:0]    r_remaining;
  logic [2:0]    r_operation;
  logic          r_busy;

  logic [2:0]    w_press;
  logic [2:0]    w_sel;

  // Two-FF synchroniser for the asynchronous buttons.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 3'b111;
      r_sync2 <= 3'b111;
    end else begin
      r_sync1 <= key_n;
      r_sync2 <= r_sync1;
    end
  end

  // Per-key debounce: level accepted after DEBOUNCE_CYCLES consecutive differing clocks.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_deb      <= 3'b111;
      r_deb_prev <= 3'b111;
      for (int k = 0; k < 3; k++) begin
        r_deb_cnt[k] <= '0;
      end
    end else begin
      r_deb_prev <= r_deb;
      for (int k = 0; k < 3; k++) begin
        if (r_sync2[k] == r_deb[k]) begin
          r_deb_cnt[k] <= '0;
        end else if (r_deb_cnt[k] == DEB_LAST) begin
          r_deb[k]     <= r_sync2[k];
          r_deb_cnt[k] <= '0;
        end else begin
          r_deb_cnt[k] <= r_deb_cnt[k] + DW'(1);
        end
      end
    end
  end

  // Press event: one-cycle strobe on a debounced 1->0 transition only.
  always_comb begin
    w_press = r_deb_prev & ~r_deb;
    w_sel   = f_select(w_press);
  end

  // Frame tick divider; holds its count while paused.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tick_cnt <= '0;
      r_update   <= 1'b0;
    end else if (enable) begin
      if (r_tick_cnt == TICK_LAST) begin
        r_tick_cnt <= '0;
        r_update   <= 1'b1;
      end else begin
        r_tick_cnt <= r_tick_cnt + TW'(1);
        r_update   <= 1'b0;
      end
    end else begin
      r_update <= 1'b0;
    end
  end

  // Action FSM: launches one sequence at a time and counts its update ticks down.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_remaining <= 5'd0;
      r_operation <= 3'b000;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (enable && (w_press != 3'b000)) begin
            r_operation <= w_sel;
            r_remaining <= f_len(w_sel);
            r_state     <= S_ACTIVE;
            r_busy      <= 1'b1;
          end else begin
            r_operation <= 3'b000;
            r_busy      <= 1'b0;
          end
        end
        S_ACTIVE: begin
          r_operation <= 3'b000;
          // An update visible in the launch cycle belongs to the previous frame.
          if (r_update && (r_operation == 3'b000)) begin
            if (r_remaining <= 5'd1) begin
              r_remaining <= 5'd0;
              r_state     <= S_IDLE;
              r_busy      <= 1'b0;
            end else begin
              r_remaining <= r_remaining - 5'd1;
            end
          end else begin
            r_remaining <= r_remaining;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_remaining <= 5'd0;
          r_operation <= 3'b000;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign operation = r_operation;
  assign update    = r_update;
  assign busy      = r_busy;

endmodule
